// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT sizing constants and the bit-reversal helper.
//   data_width : coefficient word width
//   addr_width : log2(n), width of bank addresses and frame counters
//   n          : words per frame
package ntt_pkg;
    localparam int data_width = 64;
    localparam int addr_width = 3;
    localparam int n = 2 ** addr_width;

    function automatic logic [addr_width-1:0] bitrev(input logic [addr_width-1:0] a);
        logic [addr_width-1:0] r;
        for (int i = 0; i < addr_width; i++) r[i] = a[addr_width-1-i];
        return r;
    endfunction
endpackage

// File: rtl/ntt_bitrev_reorder_if.sv
// ntt_bitrev_reorder_if: stream bundle between the SDF pipeline and the reorder stage.
//   in_valid/reorder_in             : bit-reversed input stream (master -> slave)
//   reorder_out/out_valid/done_tick : natural-order output stream (slave -> master)
interface ntt_bitrev_reorder_if import ntt_pkg::*; ();
    logic                  in_valid;
    logic [data_width-1:0] reorder_in;
    logic [data_width-1:0] reorder_out;
    logic                  out_valid;
    logic                  done_tick;

    modport master (output in_valid, reorder_in, input reorder_out, out_valid, done_tick);
    modport slave  (input in_valid, reorder_in, output reorder_out, out_valid, done_tick);
endinterface

// File: rtl/ntt_pingpong_ram.sv
// ntt_pingpong_ram: two banks of n words, one synchronous write port and one asynchronous read port.
//   clk                                  : write clock
//   we_i, wr_bank_i, wr_addr_i, wr_data_i : write port
//   rd_bank_i, rd_addr_i, rd_data_o       : combinational read port
module ntt_pingpong_ram #(
    parameter int data_width = 64,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  wr_bank_i,
    input  logic [addr_width-1:0] wr_addr_i,
    input  logic [data_width-1:0] wr_data_i,
    input  logic                  rd_bank_i,
    input  logic [addr_width-1:0] rd_addr_i,
    output logic [data_width-1:0] rd_data_o
);
    logic [data_width-1:0] mem_q [2 ** (addr_width + 1)];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end

    assign rd_data_o = mem_q[{rd_bank_i, rd_addr_i}];
endmodule

// File: rtl/ntt_bitrev_reorder.sv
// ntt_bitrev_reorder: reorders bit-reversed n-word frames into natural order through a ping-pong buffer.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of ntt_bitrev_reorder_if (input stream in, registered natural-order stream out)
module ntt_bitrev_reorder import ntt_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    ntt_bitrev_reorder_if.slave bus
);
    logic [addr_width-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]            full_q, full_d;
    logic [data_width-1:0] out_q, out_d, rd_data;
    logic                  out_valid_q, out_valid_d, done_q, done_d;
    logic                  wr_last, rd_go, rd_last;

    ntt_pingpong_ram #(.data_width(data_width), .addr_width(addr_width)) u_ram (
        .clk       (clk),
        .we_i      (bus.in_valid),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (bitrev(wr_cnt_q)),
        .wr_data_i (bus.reorder_in),
        .rd_bank_i (rd_bank_q),
        .rd_addr_i (rd_cnt_q),
        .rd_data_o (rd_data)
    );

    // Frames are written to alternating banks, so rd_bank simply toggles after
    // each read frame and always points at the oldest full bank.
    always_comb begin
        wr_last     = bus.in_valid && wr_cnt_q == addr_width'(n - 1);
        rd_go       = full_q[rd_bank_q];
        rd_last     = rd_go && rd_cnt_q == addr_width'(n - 1);
        wr_cnt_d    = bus.in_valid ? wr_cnt_q + addr_width'(1) : wr_cnt_q;
        wr_bank_d   = wr_last ? ~wr_bank_q : wr_bank_q;
        rd_cnt_d    = rd_go ? rd_cnt_q + addr_width'(1) : rd_cnt_q;
        rd_bank_d   = rd_last ? ~rd_bank_q : rd_bank_q;
        full_d      = full_q;
        if (rd_last) full_d[rd_bank_q] = 1'b0;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
        out_d       = rd_go ? rd_data : out_q;
        out_valid_d = rd_go;
        done_d      = rd_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.reorder_out = out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.done_tick   = done_q;

    // A bank still waiting to be read must never be overwritten.
    assert property (@(posedge clk) disable iff (!rst_n) bus.in_valid |-> !full_q[wr_bank_q]);
endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
module tb_ntt_bitrev_reorder;
    typedef struct {
        logic        vld;
        logic [63:0] din;
        logic        ev;
        logic [63:0] eo;
        logic        ed;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    logic [63:0] coef [8];
    logic [63:0] br [8];

    ntt_bitrev_reorder_if bus ();

    ntt_bitrev_reorder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic v, input logic [63:0] d, input logic ev, input logic [63:0] eo, input logic ed);
        vec_t t;
        t.vld = v;
        t.din = d;
        t.ev  = ev;
        t.eo  = eo;
        t.ed  = ed;
        tbl.push_back(t);
    endtask

    task automatic check(input string nm, input logic ev, input logic [63:0] eo, input logic ed, input logic cd);
        n_vec++;
        if (bus.out_valid !== ev || bus.done_tick !== ed || (cd && bus.reorder_out !== eo)) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b out=%0h done=%0b, expected valid=%0b out=%0h done=%0b",
                     nm, bus.out_valid, bus.reorder_out, bus.done_tick, ev, eo, ed);
        end
    endtask

    task automatic step(input logic v, input logic [63:0] d);
        bus.in_valid   = v;
        bus.reorder_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string nm);
        rst_n = 1'b0;
        #1;
        check(nm, 1'b0, 64'd0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        br = '{64'd0, 64'd4, 64'd2, 64'd6, 64'd1, 64'd5, 64'd3, 64'd7};
        for (int k = 0; k < 8; k++) coef[k] = {$urandom, $urandom};
        // single frame
        for (int j = 0; j < 8; j++) add(1'b1, br[j], 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 8; k++) add(1'b0, 64'd0, 1'b1, 64'(k), k == 7);
        add(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        // gapped frame: 3 idle cycles between words 3 and 4
        for (int j = 0; j < 4; j++) add(1'b1, br[j], 1'b0, 64'd0, 1'b0);
        for (int j = 0; j < 3; j++) add(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        for (int j = 4; j < 8; j++) add(1'b1, br[j], 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 8; k++) add(1'b0, 64'd0, 1'b1, 64'(k), k == 7);
        add(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        // back-to-back frames, second frame = first + 8
        for (int j = 0; j < 8; j++) add(1'b1, br[j], 1'b0, 64'd0, 1'b0);
        for (int j = 0; j < 8; j++) add(1'b1, br[j] + 64'd8, 1'b1, 64'(j), j == 7);
        for (int k = 0; k < 8; k++) add(1'b0, 64'd0, 1'b1, 64'(8 + k), k == 7);
        add(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        // full-width coefficients presented in bit-reversed order
        for (int j = 0; j < 8; j++) add(1'b1, coef[br[j][2:0]], 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 8; k++) add(1'b0, 64'd0, 1'b1, coef[k], k == 7);
        add(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);

        bus.in_valid   = 1'b0;
        bus.reorder_in = '0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", 1'b0, 64'd0, 1'b0, 1'b1);
        #9 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vld, tbl[i].din);
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eo, tbl[i].ed, tbl[i].ev);
        end

        // reset in the middle of a write frame
        for (int j = 0; j < 5; j++) begin
            step(1'b1, 64'd99 + 64'(j));
            check("partial_wr", 1'b0, 64'd0, 1'b0, 1'b0);
        end
        reset_pulse("rst_mid_wr");
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 64'd16 + br[j]);
            check("after_rst_wr", 1'b0, 64'd0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 64'd0);
            check($sformatf("after_rst_out%0d", k), 1'b1, 64'(16 + k), k == 7, 1'b1);
        end
        step(1'b0, 64'd0);
        check("after_rst_idle", 1'b0, 64'd0, 1'b0, 1'b0);

        // reset in the middle of a read frame
        for (int j = 0; j < 8; j++) step(1'b1, 64'd32 + br[j]);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 64'd0);
            check($sformatf("pre_rst_rd%0d", k), 1'b1, 64'(32 + k), 1'b0, 1'b1);
        end
        reset_pulse("rst_mid_rd");
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 64'd0);
            check("rd_discarded", 1'b0, 64'd0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
